// File: rtl/baby_vga_fb_arbiter_if.sv
// Bundle between the arbiter and its three neighbours: video fetch, CPU row port, framebuffer port.
// slave = arbiter side, master = environment side (timing generator, register interface, framebuffer).
interface baby_vga_fb_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_row;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              vid_overrun;

  logic              cpu_rd_req;
  logic              cpu_wr_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_row, cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wdata, mem_rdata,
    output vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_req, vid_row, cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/baby_vga_fb_arbiter.sv
// Framebuffer port arbiter: video scanout vs CPU, video first but strictly alternating under contention.
// Grant-to-ready latency LATENCY, one IDLE cycle between accesses. FB_ARB_STATS_EN adds overrun/wait statistics.
module baby_vga_fb_arbiter #(
  parameter int ROWS    = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  baby_vga_fb_arbiter_if.slave  bus
`ifdef FB_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [7:0]            ovr_count,
  output logic [7:0]            cpu_wait_max
`endif
);

  localparam int CNT_W = $clog2(LATENCY);

  generate
    if (ROWS > (1 << ADDR_W) || LATENCY < 2) begin : g_bad_cfg
      $error("baby_vga_fb_arbiter: ROWS must fit in ADDR_W and LATENCY must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, VID, CPU_RD, CPU_WR} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              vid_pend_q;
  logic [ADDR_W-1:0] vid_row_q;
  logic              last_vid_q;
  logic [DATA_W-1:0] vid_data_q;
  logic              vid_valid_q;
  logic              vid_overrun_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_ready_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic cpu_pend;
  logic vid_elig;
  logic grant_vid;
  logic grant_cpu;

  // The CPU is blind during its own ready cycle so a still-high request is not served twice.
  assign cpu_pend  = (bus.cpu_rd_req | bus.cpu_wr_req) & ~cpu_ready_q;
  assign vid_elig  = vid_pend_q | bus.vid_req;
  assign grant_vid = (state_q == IDLE) & vid_elig & ~(last_vid_q & cpu_pend);
  assign grant_cpu = (state_q == IDLE) & ~grant_vid & cpu_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      vid_pend_q    <= 1'b0;
      vid_row_q     <= '0;
      last_vid_q    <= 1'b0;
      vid_data_q    <= '0;
      vid_valid_q   <= 1'b0;
      vid_overrun_q <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      vid_valid_q   <= 1'b0;
      cpu_ready_q   <= 1'b0;
      // A request landing on the edge that consumes the pending one is queued, not lost.
      vid_overrun_q <= bus.vid_req & vid_pend_q & ~grant_vid;

      if (bus.vid_req) begin
        vid_row_q <= bus.vid_row;
      end
      if (grant_vid) begin
        vid_pend_q <= vid_pend_q & bus.vid_req;
      end else if (bus.vid_req) begin
        vid_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (grant_vid) begin
            state_q     <= VID;
            last_vid_q  <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= vid_pend_q ? vid_row_q : bus.vid_row;
            mem_wdata_q <= '0;
            cnt_q       <= CNT_W'(LATENCY - 1);
          end else if (grant_cpu) begin
            state_q     <= bus.cpu_wr_req ? CPU_WR : CPU_RD;
            last_vid_q  <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.cpu_wr_req;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            cnt_q       <= CNT_W'(LATENCY - 1);
          end
        end
        default: begin
          if (cnt_q == '0) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (state_q == VID) begin
              vid_data_q  <= bus.mem_rdata;
              vid_valid_q <= 1'b1;
            end else begin
              if (state_q == CPU_RD) begin
                cpu_rdata_q <= bus.mem_rdata;
              end
              cpu_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.vid_data    = vid_data_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.vid_overrun = vid_overrun_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_ready   = cpu_ready_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

`ifdef FB_ARB_STATS_EN
  logic [7:0] ovr_cnt_q;
  logic [7:0] wait_max_q;
  logic [7:0] wait_cnt_q;

  // Wait counts edges where the CPU is eligible but not granted; it restarts whenever the CPU is not waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_cnt_q  <= '0;
      wait_max_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (stats_clr) begin
        ovr_cnt_q <= '0;
      end else if (vid_overrun_q && ovr_cnt_q != 8'hFF) begin
        ovr_cnt_q <= ovr_cnt_q + 8'd1;
      end

      if (grant_cpu) begin
        wait_cnt_q <= '0;
      end else if (cpu_pend && (state_q == IDLE || state_q == VID)) begin
        if (wait_cnt_q != 8'hFF) begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
        end
      end else begin
        wait_cnt_q <= '0;
      end

      if (stats_clr) begin
        wait_max_q <= '0;
      end else if (grant_cpu && wait_cnt_q > wait_max_q) begin
        wait_max_q <= wait_cnt_q;
      end
    end
  end

  assign ovr_count    = ovr_cnt_q;
  assign cpu_wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_baby_vga_fb_arbiter.sv
// Bench for baby_vga_fb_arbiter: table of CPU accesses plus hand sequences for contention, alternation, overrun, reset.
// Framebuffer model returns real data only on the last access cycle; scoreboards check vid_data/cpu_rdata.
module tb_baby_vga_fb_arbiter;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int LATENCY = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  baby_vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FB_ARB_STATS_EN
  logic       stats_clr;
  logic [7:0] ovr_count;
  logic [7:0] cpu_wait_max;
`endif

  baby_vga_fb_arbiter #(.ROWS(16), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FB_ARB_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .ovr_count    (ovr_count),
    .cpu_wait_max (cpu_wait_max)
`endif
  );

  function automatic logic [31:0] init_row(input int i);
    if (i == 3) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0011_0101;
  endfunction

  // Framebuffer model
  logic [31:0] fb [16];
  int          acc_cyc;
  always @(posedge clk) begin
    if (rst) begin
      acc_cyc <= 0;
      for (int i = 0; i < 16; i++) fb[i] <= init_row(i);
    end else begin
      acc_cyc <= bus.mem_en ? acc_cyc + 1 : 0;
      if (bus.mem_en && bus.mem_we && acc_cyc == LATENCY - 1) fb[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = (bus.mem_en && acc_cyc == LATENCY - 1) ? fb[bus.mem_addr] : 32'hBADBAD00;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wd;
  } grant_t;

  grant_t      grant_q [$];
  logic [31:0] vq [$];
  logic [31:0] cq [$];
  int          ovr_seen = 0;

  // Monitor: access shape, latency and data scoreboards
  int     cyc = 0;
  int     t_grant = 0;
  bit     in_acc = 0;
  int     acc_len;
  bit     stable;
  grant_t cur;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_acc = 0;
    end else begin
      if (bus.mem_en && !in_acc) begin
        in_acc  = 1;
        acc_len = 1;
        stable  = 1;
        t_grant = cyc;
        cur     = '{we: bus.mem_we, addr: bus.mem_addr, wd: bus.mem_wdata};
        grant_q.push_back(cur);
      end else if (bus.mem_en && in_acc) begin
        acc_len++;
        if (bus.mem_we !== cur.we || bus.mem_addr !== cur.addr || bus.mem_wdata !== cur.wd) stable = 0;
      end else if (!bus.mem_en && in_acc) begin
        in_acc = 0;
        chk("acc_len", 128'(acc_len), 128'(LATENCY));
        chk("acc_stable", 128'(stable), 128'd1);
      end
      if (bus.vid_valid) begin
        chk("vid_latency", 128'(cyc - t_grant), 128'(LATENCY));
        if (vq.size() == 0) chk("vid_valid_unexpected", 128'd1, 128'd0);
        else chk("vid_data", 128'(bus.vid_data), 128'(vq.pop_front()));
      end
      if (bus.cpu_ready) begin
        chk("cpu_latency", 128'(cyc - t_grant), 128'(LATENCY));
        if (cq.size() == 0) chk("cpu_ready_unexpected", 128'd1, 128'd0);
        else chk("cpu_rdata", 128'(bus.cpu_rdata), 128'(cq.pop_front()));
      end
      if (bus.vid_overrun) ovr_seen++;
    end
  end

  logic [104:0] all_out;
  assign all_out = {bus.vid_data, bus.vid_valid, bus.vid_overrun, bus.cpu_rdata, bus.cpu_ready,
                    bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};

  int rdy_cnt = 0;
  task automatic step();
    @(negedge clk);
    if (bus.cpu_ready) rdy_cnt++;
  endtask

  task automatic wait_ready(input string name, output int n);
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk({name, "_ready_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic drain_vid(input string name);
    for (int k = 0; k < 60 && vq.size() != 0; k++) @(negedge clk);
    chk({name, "_vid_drained"}, 128'(vq.size()), 128'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tv [6];

  initial begin
    int     n;
    int     ovr0;
    grant_t g;
    logic [3:0] exp_order [5];

    tv[0] = '{1'b0, 4'd3,  32'h0,        32'hDEADBEEF};
    tv[1] = '{1'b1, 4'd5,  32'h12345678, 32'hDEADBEEF};
    tv[2] = '{1'b0, 4'd5,  32'h0,        32'h12345678};
    tv[3] = '{1'b1, 4'd15, 32'hCAFEF00D, 32'h12345678};
    tv[4] = '{1'b0, 4'd15, 32'h0,        32'hCAFEF00D};
    tv[5] = '{1'b0, 4'd0,  32'h0,        32'h10000000};

    rst            = 1'b1;
    bus.vid_req    = 1'b0;
    bus.vid_row    = '0;
    bus.cpu_rd_req = 1'b0;
    bus.cpu_wr_req = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
`ifdef FB_ARB_STATS_EN
    stats_clr      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'(all_out), 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", 128'(all_out), 128'd0);
`ifdef FB_ARB_STATS_EN
    chk("reset_ovr_count", 128'(ovr_count), 128'd0);
    chk("reset_wait_max", 128'(cpu_wait_max), 128'd0);
`endif

    // CPU read held through its ready cycle: no second grant
    grant_q.delete();
    cq.push_back(32'hDEADBEEF);
    bus.cpu_rd_req = 1'b1;
    bus.cpu_addr   = 4'd3;
    wait_ready("A", n);
    chk("A_grant_to_ready", 128'(n), 128'(LATENCY + 1));
    @(negedge clk);
    chk("A_no_regrant", 128'(bus.mem_en), 128'd0);
    bus.cpu_rd_req = 1'b0;
    chk("A_grants", 128'(grant_q.size()), 128'd1);

    // Table of CPU reads and writes
    for (int i = 0; i < 6; i++) begin
      grant_q.delete();
      cq.push_back(tv[i].exp_rdata);
      bus.cpu_addr   = tv[i].addr;
      bus.cpu_wdata  = tv[i].wdata;
      bus.cpu_wr_req = tv[i].wr;
      bus.cpu_rd_req = ~tv[i].wr;
      wait_ready("tv", n);
      bus.cpu_rd_req = 1'b0;
      bus.cpu_wr_req = 1'b0;
      @(negedge clk);
      chk("tv_grants", 128'(grant_q.size()), 128'd1);
      if (grant_q.size() != 0) begin
        g = grant_q.pop_front();
        chk("tv_mem_addr", 128'(g.addr), 128'(tv[i].addr));
        chk("tv_mem_we", 128'(g.we), 128'(tv[i].wr));
        if (tv[i].wr) chk("tv_mem_wdata", 128'(g.wd), 128'(tv[i].wdata));
      end
    end

    // Contention with last_vid=0: video first, CPU ready 18 cycles after the request
    grant_q.delete();
    vq.push_back(init_row(7));
    cq.push_back(init_row(1));
    bus.vid_req    = 1'b1;
    bus.vid_row    = 4'd7;
    bus.cpu_rd_req = 1'b1;
    bus.cpu_addr   = 4'd1;
    @(negedge clk);
    bus.vid_req = 1'b0;
    wait_ready("C", n);
    bus.cpu_rd_req = 1'b0;
    chk("C_total_cycles", 128'(n + 1), 128'd18);
    chk("C_grants", 128'(grant_q.size()), 128'd2);
    if (grant_q.size() == 2) begin
      chk("C_first_addr", 128'(grant_q[0].addr), 128'd7);
      chk("C_second_addr", 128'(grant_q[1].addr), 128'd1);
    end
    drain_vid("C");
`ifdef FB_ARB_STATS_EN
    chk("C_wait_max", 128'(cpu_wait_max), 128'd9);
`endif

    // Alternation: CPU held, vid_req every 9 cycles
    grant_q.delete();
    ovr0    = ovr_seen;
    rdy_cnt = 0;
    cq.push_back(init_row(4));
    cq.push_back(init_row(4));
    for (int k = 0; k < 3; k++) vq.push_back(init_row(10 + k));
    bus.cpu_rd_req = 1'b1;
    bus.cpu_addr   = 4'd4;
    for (int k = 0; k < 3; k++) begin
      bus.vid_req = 1'b1;
      bus.vid_row = 4'(10 + k);
      step();
      bus.vid_req = 1'b0;
      repeat (8) step();
    end
    for (int k = 0; k < 60 && rdy_cnt < 2; k++) step();
    bus.cpu_rd_req = 1'b0;
    chk("D_cpu_readies", 128'(rdy_cnt), 128'd2);
    drain_vid("D");
    exp_order = '{4'd10, 4'd4, 4'd11, 4'd4, 4'd12};
    chk("D_grants", 128'(grant_q.size()), 128'd5);
    if (grant_q.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("D_grant_order", 128'(grant_q[k].addr), 128'(exp_order[k]));
    end
    chk("D_no_overrun", 128'(ovr_seen - ovr0), 128'd0);

    // Overrun: second vid_req while the first is still pending behind a CPU access
    grant_q.delete();
    ovr0 = ovr_seen;
    cq.push_back(init_row(6));
    vq.push_back(init_row(9));
    bus.cpu_rd_req = 1'b1;
    bus.cpu_addr   = 4'd6;
    repeat (2) @(negedge clk);
    bus.vid_req = 1'b1;
    bus.vid_row = 4'd2;
    @(negedge clk);
    bus.vid_req = 1'b0;
    @(negedge clk);
    bus.vid_req = 1'b1;
    bus.vid_row = 4'd9;
    @(negedge clk);
    bus.vid_req = 1'b0;
    wait_ready("E", n);
    bus.cpu_rd_req = 1'b0;
    drain_vid("E");
    chk("E_overrun_pulses", 128'(ovr_seen - ovr0), 128'd1);
    chk("E_grants", 128'(grant_q.size()), 128'd2);
    if (grant_q.size() == 2) chk("E_vid_addr", 128'(grant_q[1].addr), 128'd9);
`ifdef FB_ARB_STATS_EN
    chk("E_ovr_count", 128'(ovr_count), 128'd1);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("E_clr_ovr_count", 128'(ovr_count), 128'd0);
    chk("E_clr_wait_max", 128'(cpu_wait_max), 128'd0);
`endif

    // Reset during cycle 4 of a CPU read, then the held request completes
    cq.push_back(32'hDEADBEEF);
    bus.cpu_rd_req = 1'b1;
    bus.cpu_addr   = 4'd3;
    repeat (4) @(negedge clk);
    chk("F_in_access", 128'(bus.mem_en), 128'd1);
    #2 rst = 1'b1;
    #1 chk("F_reset_outputs", 128'(all_out), 128'd0);
    rdy_cnt = 0;
    repeat (2) step();
    chk("F_no_ready_in_reset", 128'(rdy_cnt), 128'd0);
    rst = 1'b0;
    wait_ready("F", n);
    chk("F_regrant_to_ready", 128'(n), 128'(LATENCY + 1));
    bus.cpu_rd_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("F_scoreboard_empty", 128'(cq.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/baby_vga_fb_arbiter.md
Name: baby_vga_fb_arbiter

Overview:
- Arbitrates the single framebuffer access port between two requesters: the video scanout (one row fetch per scanline) and the CPU bus (32-bit row reads and writes).
- Sits between the VGA timing generator, the TinyQV register interface and the framebuffer.
- Video has priority, but strict alternation prevents CPU starvation.
- The framebuffer port has a fixed LATENCY; the arbiter sequences each access and returns the data.

Parameters:
ROWS, 16, number of framebuffer rows
ADDR_W, 4, row address width (log2 ROWS)
DATA_W, 32, row width in bits
LATENCY, 8, framebuffer access duration in cycles (>=2)

Ports:
clk  in  1  single clock for the block
rst  in  1  reset; asynchronous, active-high
vid_req  in  1  one-cycle pulse: fetch row vid_row
vid_row  in  ADDR_W  row for the video fetch; sampled with vid_req
vid_data  out  DATA_W  last fetched video row; held until the next fetch
vid_valid  out  1  one-cycle pulse when vid_data updates
vid_overrun  out  1  one-cycle pulse when vid_req arrives while a video fetch is still pending
cpu_rd_req  in  1  level; held until cpu_ready
cpu_wr_req  in  1  level; held until cpu_ready
cpu_addr  in  ADDR_W  CPU row address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read result; valid while cpu_ready is high
cpu_ready  out  1  one-cycle completion pulse
mem_en  out  1  high for the whole access
mem_we  out  1  write strobe; high for the whole write access
mem_addr  out  ADDR_W  access row; stable for the whole access
mem_wdata  out  DATA_W  write data; stable for the whole access
mem_rdata  in  DATA_W  framebuffer read data; valid on the last access cycle

Behaviour:
- Reset (asynchronous, any time, including mid-access):
  - state goes to IDLE; all outputs go to 0 (vid_data=0, cpu_rdata=0).
  - vid_pend, last_vid and cnt are cleared.
  - An interrupted access is abandoned; no ready or valid pulse is produced.
- States:
  - IDLE: no access in progress.
  - VID: video fetch in progress.
  - CPU_RD: CPU read in progress.
  - CPU_WR: CPU write in progress.
- Video request capture:
  - vid_req sets vid_pend and latches vid_row into vid_row_q, in any state.
  - If vid_pend is already set: vid_row_q is overwritten with the new row, and vid_overrun pulses on the following cycle.
  - vid_pend clears on the edge that enters VID.
- CPU eligibility:
  - cpu_pend = (cpu_rd_req | cpu_wr_req) & !cpu_ready.
  - The CPU is therefore ineligible during its own ready cycle; this prevents double service.
  - If cpu_rd_req and cpu_wr_req are both high, the write wins.
- Grant (evaluated at each edge while in IDLE):
  - vid_pend & !(last_vid & cpu_pend) -> VID.
  - else cpu_pend -> CPU_WR or CPU_RD.
  - else stay in IDLE.
  - last_vid is set on entering VID and cleared on entering a CPU state.
- Access timing:
  - On entering a busy state: mem_addr, mem_we and mem_wdata are loaded, and cnt=LATENCY-1.
  - mem_en is high for exactly LATENCY cycles.
  - cnt decrements each edge.
  - At the edge where cnt==0: mem_rdata is captured into vid_data (VID) or cpu_rdata (CPU_RD), the state returns to IDLE, and vid_valid or cpu_ready pulses for one cycle.
  - A write also pulses cpu_ready; cpu_rdata is unchanged on a write.
- Latency and throughput:
  - Grant edge to ready/valid is LATENCY cycles.
  - There is at least one IDLE cycle between accesses, so throughput is 1 access per LATENCY+1 cycles.
- Worst-case video wait is 2*(LATENCY+1) cycles: one CPU access completes, then video is granted.
- CPU inputs are sampled only at the grant edge; later changes do not affect the access in progress.
- Address wrap: rows >= ROWS are not possible when ROWS=2^ADDR_W; otherwise the address is truncated modulo 2^ADDR_W.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- When defined, the block adds:
  - output ovr_count[7:0]: saturating count of vid_overrun pulses.
  - output cpu_wait_max[7:0]: saturating maximum number of cycles any CPU request waited from cpu_pend rising to grant.
  - input stats_clr: synchronous clear of both counters.
  - All three reset to 0.
- When undefined, these ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- CPU read alone: rst released, cpu_rd_req=1, cpu_addr=3, framebuffer row 3 = 0xDEADBEEF -> mem_en high for 8 cycles with mem_addr=3 and mem_we=0; cpu_ready pulses 8 cycles after the grant with cpu_rdata=0xDEADBEEF; no second grant while cpu_ready is high.
- CPU write: cpu_wr_req=1, cpu_addr=5, cpu_wdata=0x12345678 -> mem_we=1 with mem_addr=5 and mem_wdata=0x12345678 stable for 8 cycles; cpu_ready pulses once; cpu_rdata unchanged.
- Contention: vid_req (row 7) and cpu_rd_req arrive in the same cycle with last_vid=0 -> VID is served first (vid_valid, vid_data=row 7); the CPU is granted in the next IDLE cycle; total time to cpu_ready = 18 cycles.
- Alternation: back-to-back vid_req every 9 cycles while cpu_rd_req is held -> grant order VID, CPU, VID, CPU; no vid_overrun.
- Overrun: vid_req row 2, then vid_req row 9 while the first is still pending (CPU access in progress) -> vid_overrun pulses once; the single VID access uses mem_addr=9; ovr_count=1 when FB_ARB_STATS_EN is defined.
- Reset mid-access: assert rst during cycle 4 of a CPU_RD -> mem_en drops immediately, no cpu_ready pulse, all outputs 0; after release, the still-held request is re-granted and completes normally.
